// File: rtl/delta_scheduler_pkg.sv
// delta_scheduler_pkg: shared state codes, polarity constants and counter limit
package delta_scheduler_pkg;
    typedef logic [1:0] state_t;
    localparam state_t SCAN = 2'd0;
    localparam state_t CMP  = 2'd1;
    localparam state_t EMIT = 2'd2;
    localparam logic POL_ON  = 1'b1;
    localparam logic POL_OFF = 1'b0;
    localparam logic [7:0] CNT_MAX = 8'd255;
endpackage

// File: rtl/delta_cmp.sv
// delta_cmp: shared combinational delta comparator producing spike decisions
module delta_cmp #(
    parameter int DW = 4
) (
    input  logic [DW-1:0] data,
    input  logic [DW-1:0] prev,
    input  logic [DW-1:0] threshold,
    input  logic          off_spike,
    output logic          fire,
    output logic          pol,
    output logic          update_prev
);
    import delta_scheduler_pkg::*;
    logic          rising;
    logic [DW-1:0] diff;
    // magnitude taken as max-min so it never wraps; off spikes may be suppressed but still move prev
    always_comb begin
        rising      = data > prev;
        diff        = rising ? data - prev : prev - data;
        update_prev = diff > threshold;
        pol         = rising ? POL_ON : POL_OFF;
        fire        = update_prev && (rising || off_spike);
    end
endmodule

// File: rtl/delta_scheduler.sv
// delta_scheduler: round-robin time-multiplexing of one delta comparator over NCH channels
module delta_scheduler #(
    parameter int NCH = 4,
    parameter int DW  = 4,
    localparam int CW = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [DW-1:0]     cfg_threshold,
    input  logic              cfg_off_spike,
    input  logic [NCH-1:0]    sample_valid,
    input  logic [NCH*DW-1:0] sample_data,
    output logic [NCH-1:0]    sample_ready,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CW-1:0]     evt_chan,
    output logic              evt_pol,
    output logic              busy,
    output logic [7:0]        evt_count
);
    import delta_scheduler_pkg::*;
    state_t        state;
    logic [CW-1:0] rr_ptr;
    logic [CW-1:0] ch_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] prev [NCH];
    logic [DW-1:0] threshold;
    logic          off_spike;
    logic          found;
    logic [CW-1:0] sel;
    logic [CW-1:0] idx;
    logic          fire;
    logic          pol;
    logic          update_prev;

    delta_cmp #(.DW(DW)) u_cmp (
        .data        (data_q),
        .prev        (prev[ch_q]),
        .threshold   (threshold),
        .off_spike   (off_spike),
        .fire        (fire),
        .pol         (pol),
        .update_prev (update_prev)
    );

    // first valid channel at or after rr_ptr, wrapping modulo NCH
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = rr_ptr + CW'(k);
            if (!found && sample_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign sample_ready = (rst_n && state == SCAN && found) ? NCH'(1) << sel : '0;
    assign evt_valid    = state == EMIT;
    assign busy         = state != SCAN;

    // scan / compare / emit sequencing plus configuration capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            rr_ptr    <= '0;
            ch_q      <= '0;
            data_q    <= '0;
            threshold <= '0;
            off_spike <= 1'b0;
            evt_chan  <= '0;
            evt_pol   <= 1'b0;
            evt_count <= '0;
            for (int i = 0; i < NCH; i++) prev[i] <= '0;
        end else begin
            if (cfg_we) begin
                threshold <= cfg_threshold;
                off_spike <= cfg_off_spike;
            end
            case (state)
                SCAN: if (found) begin
                    ch_q   <= sel;
                    data_q <= sample_data[sel*DW +: DW];
                    state  <= CMP;
                end
                CMP: begin
                    if (update_prev) prev[ch_q] <= data_q;
                    rr_ptr <= ch_q + CW'(1);
                    if (fire) begin
                        evt_chan <= ch_q;
                        evt_pol  <= pol;
                    end
                    state <= fire ? EMIT : SCAN;
                end
                EMIT: if (evt_ready) begin
                    if (evt_count != CNT_MAX) evt_count <= evt_count + 8'd1;
                    state <= SCAN;
                end
                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_delta_scheduler.sv
// tb_delta_scheduler: scenario tasks checked against a behavioural delta/spike model
module tb_delta_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_threshold = '0;
    logic        cfg_off_spike = 1'b0;
    logic [3:0]  sample_valid = '0;
    logic [15:0] sample_data = '0;
    logic [3:0]  sample_ready;
    logic        evt_valid;
    logic        evt_ready = 1'b1;
    logic [1:0]  evt_chan;
    logic        evt_pol;
    logic        busy;
    logic [7:0]  evt_count;

    int checks = 0;
    int passes = 0;
    int prev_m [4];
    int thr_m, off_m, cnt_m;

    delta_scheduler #(.NCH(4), .DW(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_threshold(cfg_threshold),
        .cfg_off_spike(cfg_off_spike), .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_ready(sample_ready), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_chan(evt_chan), .evt_pol(evt_pol), .busy(busy), .evt_count(evt_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset;
        for (int i = 0; i < 4; i++) prev_m[i] = 0;
        thr_m = 0; off_m = 0; cnt_m = 0;
    endtask

    task automatic model_step(input int ch, input int d, output int fire, output int pol);
        int diff;
        diff = d > prev_m[ch] ? d - prev_m[ch] : prev_m[ch] - d;
        pol = d > prev_m[ch] ? 1 : 0;
        fire = 0;
        if (diff > thr_m) begin
            fire = (pol == 1 || off_m == 1) ? 1 : 0;
            prev_m[ch] = d;
        end
        if (fire == 1) cnt_m = cnt_m < 255 ? cnt_m + 1 : 255;
    endtask

    task automatic set_cfg(input int thr, input int off);
        cfg_threshold = 4'(thr); cfg_off_spike = off[0]; cfg_we = 1'b1;
        @(negedge clk); #1;
        cfg_we = 1'b0;
        thr_m = thr; off_m = off;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; sample_valid = '0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        model_reset;
    endtask

    task automatic run_sample(input int ch, input int d, output int ev, output int ech,
                              output int epol, output int cyc, output logic [3:0] rdy);
        int n = 0;
        sample_data[ch*4 +: 4] = 4'(d);
        sample_valid = 4'(1 << ch);
        #1;
        while (!sample_ready[ch] && n < 20) begin @(negedge clk); #1; n++; end
        rdy = sample_ready;
        @(posedge clk); #1;
        sample_valid = '0;
        cyc = 0;
        do begin @(negedge clk); #1; cyc++; end while (busy && !evt_valid && cyc < 20);
        if (n == 20) cyc = -1;
        ev = int'(evt_valid); ech = int'(evt_chan); epol = int'(evt_pol);
        if (evt_valid && evt_ready) begin @(negedge clk); #1; end
    endtask

    task automatic test_reset;
        sample_valid = 4'hf; #1;
        checks++; if (sample_ready !== 4'b0000) $display("FAIL reset_ready got %b exp 0000", sample_ready); else passes++;
        checks++; if (evt_valid !== 1'b0) $display("FAIL reset_evt_valid got %b exp 0", evt_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passes++;
        checks++; if (evt_count !== 8'd0) $display("FAIL reset_count got %0d exp 0", evt_count); else passes++;
        checks++; if (evt_chan !== 2'd0 || evt_pol !== 1'b0) $display("FAIL reset_chan_pol got %0d/%b exp 0/0", evt_chan, evt_pol); else passes++;
        sample_valid = '0;
        rst_n = 1'b1;
        model_reset;
        @(negedge clk); #1;
    endtask

    task automatic test_first_event;
        int ev, ech, epol, cyc, f, p;
        logic [3:0] rdy;
        set_cfg(2, 1);
        model_step(0, 5, f, p);
        run_sample(0, 5, ev, ech, epol, cyc, rdy);
        checks++; if (rdy !== 4'b0001) $display("FAIL first_ready got %b exp 0001", rdy); else passes++;
        checks++; if (ev != f || cyc != 2) $display("FAIL first_evt got ev=%0d cyc=%0d exp ev=%0d cyc=2", ev, cyc, f); else passes++;
        checks++; if (ech != 0 || epol != p) $display("FAIL first_chan_pol got %0d/%0d exp 0/%0d", ech, epol, p); else passes++;
        checks++; if (int'(dut.prev[0]) != prev_m[0]) $display("FAIL first_prev got %0d exp %0d", dut.prev[0], prev_m[0]); else passes++;
        checks++; if (int'(evt_count) != cnt_m) $display("FAIL first_count got %0d exp %0d", evt_count, cnt_m); else passes++;
    endtask

    task automatic test_no_spike;
        int ev, ech, epol, cyc, f, p;
        logic [3:0] rdy;
        model_step(0, 6, f, p);
        run_sample(0, 6, ev, ech, epol, cyc, rdy);
        checks++; if (ev != f || cyc != 2 || busy !== 1'b0) $display("FAIL nospike got ev=%0d cyc=%0d busy=%b exp ev=%0d cyc=2 busy=0", ev, cyc, busy, f); else passes++;
        checks++; if (int'(dut.prev[0]) != prev_m[0]) $display("FAIL nospike_prev got %0d exp %0d", dut.prev[0], prev_m[0]); else passes++;
    endtask

    task automatic test_suppressed_off;
        int ev, ech, epol, cyc, f, p;
        logic [3:0] rdy;
        set_cfg(3, 0);
        model_step(1, 9, f, p);
        run_sample(1, 9, ev, ech, epol, cyc, rdy);
        checks++; if (ev != f || ech != 1) $display("FAIL off_setup got ev=%0d ch=%0d exp ev=%0d ch=1", ev, ech, f); else passes++;
        model_step(1, 2, f, p);
        run_sample(1, 2, ev, ech, epol, cyc, rdy);
        checks++; if (ev != f || cyc != 2) $display("FAIL off_suppressed got ev=%0d cyc=%0d exp ev=%0d cyc=2", ev, cyc, f); else passes++;
        checks++; if (int'(dut.prev[1]) != prev_m[1]) $display("FAIL off_prev got %0d exp %0d", dut.prev[1], prev_m[1]); else passes++;
        set_cfg(3, 1);
        model_step(1, 15, f, p);
        run_sample(1, 15, ev, ech, epol, cyc, rdy);
        checks++; if (ev != f || ech != 1 || epol != p) $display("FAIL off_then_on got ev=%0d ch=%0d pol=%0d exp ev=%0d ch=1 pol=%0d", ev, ech, epol, f, p); else passes++;
        checks++; if (int'(evt_count) != cnt_m) $display("FAIL off_count got %0d exp %0d", evt_count, cnt_m); else passes++;
    endtask

    task automatic test_round_robin;
        int exp_ch [5] = '{0, 1, 2, 3, 0};
        int got = 0, n = 0, last = 0;
        logic [3:0] d [4];
        logic [3:0] rdy;
        do_reset;
        set_cfg(2, 1);
        for (int k = 0; k < 4; k++) begin d[k] = 4'd4; sample_data[k*4 +: 4] = 4'd4; end
        sample_valid = 4'hf;
        #1;
        while (got < 5 && n < 100) begin
            rdy = sample_ready;
            if (evt_valid && evt_ready) begin
                checks++; if (int'(evt_chan) != exp_ch[got] || evt_pol !== 1'b1) $display("FAIL rr_order ev%0d got ch=%0d pol=%b exp ch=%0d pol=1", got, evt_chan, evt_pol, exp_ch[got]); else passes++;
                if (got > 0) begin
                    checks++; if (n - last != 3) $display("FAIL rr_spacing ev%0d got %0d cycles exp 3", got, n - last); else passes++;
                end
                last = n;
                got++;
            end
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) if (rdy[k]) begin d[k] = d[k] + 4'd4; sample_data[k*4 +: 4] = d[k]; end
            @(negedge clk); #1;
            n++;
        end
        checks++; if (got != 5) $display("FAIL rr_timeout got %0d events exp 5", got); else passes++;
        sample_valid = '0;
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic test_stall;
        int ev, ech, epol, cyc, f, p;
        logic [3:0] rdy;
        do_reset;
        set_cfg(1, 1);
        evt_ready = 1'b0;
        model_step(3, 7, f, p);
        run_sample(3, 7, ev, ech, epol, cyc, rdy);
        checks++; if (ev != f || cyc != 2) $display("FAIL stall_evt got ev=%0d cyc=%0d exp ev=%0d cyc=2", ev, cyc, f); else passes++;
        sample_valid = 4'hf;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            checks++; if (evt_valid !== 1'b1 || int'(evt_chan) != 3 || int'(evt_pol) != p) $display("FAIL stall_hold c%0d got v=%b ch=%0d pol=%b exp v=1 ch=3 pol=%0d", i, evt_valid, evt_chan, evt_pol, p); else passes++;
            checks++; if (sample_ready !== 4'b0000) $display("FAIL stall_ready c%0d got %b exp 0000", i, sample_ready); else passes++;
            checks++; if (evt_count !== 8'd0) $display("FAIL stall_count c%0d got %0d exp 0", i, evt_count); else passes++;
        end
        sample_valid = '0;
        evt_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (evt_valid !== 1'b0 || busy !== 1'b0 || int'(evt_count) != cnt_m) $display("FAIL stall_release got v=%b busy=%b cnt=%0d exp 0/0/%0d", evt_valid, busy, evt_count, cnt_m); else passes++;
    endtask

    task automatic test_reset_mid;
        int ev, ech, epol, cyc, f, p;
        logic [3:0] rdy;
        set_cfg(3, 1);
        evt_ready = 1'b0;
        model_step(0, 9, f, p);
        run_sample(0, 9, ev, ech, epol, cyc, rdy);
        checks++; if (ev != 1) $display("FAIL midrst_setup got ev=%0d exp 1", ev); else passes++;
        sample_valid = 4'hf;
        rst_n = 1'b0;
        #1;
        checks++; if (evt_valid !== 1'b0 || sample_ready !== 4'b0000 || busy !== 1'b0) $display("FAIL midrst_async got v=%b rdy=%b busy=%b exp 0/0000/0", evt_valid, sample_ready, busy); else passes++;
        checks++; if (evt_count !== 8'd0) $display("FAIL midrst_count got %0d exp 0", evt_count); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (dut.prev[i] !== 4'd0) $display("FAIL midrst_prev%0d got %0d exp 0", i, dut.prev[i]); else passes++;
        end
        @(negedge clk); #1;
        sample_valid = '0;
        rst_n = 1'b1;
        evt_ready = 1'b1;
        model_reset;
        set_cfg(14, 0);
        model_step(2, 15, f, p);
        run_sample(2, 15, ev, ech, epol, cyc, rdy);
        checks++; if (rdy !== 4'b0100) $display("FAIL midrst_ready got %b exp 0100", rdy); else passes++;
        checks++; if (ev != f || ech != 2 || epol != p || cyc != 2) $display("FAIL midrst_evt got ev=%0d ch=%0d pol=%0d cyc=%0d exp %0d/2/%0d/2", ev, ech, epol, cyc, f, p); else passes++;
    endtask

    task automatic test_boundary;
        int tab [7][4] = '{'{0, 0, 0, 1}, '{0, 15, 15, 1}, '{0, 15, 14, 1}, '{1, 15, 0, 1},
                           '{1, 0, 14, 0}, '{2, 0, 0, 1}, '{0, 0, 14, 1}};
        int ev, ech, epol, cyc, f, p;
        logic [3:0] rdy;
        do_reset;
        for (int i = 0; i < 7; i++) begin
            set_cfg(tab[i][2], tab[i][3]);
            model_step(tab[i][0], tab[i][1], f, p);
            run_sample(tab[i][0], tab[i][1], ev, ech, epol, cyc, rdy);
            checks++; if (ev != f || cyc != 2 || (f == 1 && (ech != tab[i][0] || epol != p))) $display("FAIL bound%0d got ev=%0d ch=%0d pol=%0d cyc=%0d exp ev=%0d ch=%0d pol=%0d", i, ev, ech, epol, cyc, f, tab[i][0], p); else passes++;
            checks++; if (int'(dut.prev[tab[i][0]]) != prev_m[tab[i][0]]) $display("FAIL bound%0d_prev got %0d exp %0d", i, dut.prev[tab[i][0]], prev_m[tab[i][0]]); else passes++;
        end
    endtask

    task automatic test_random;
        int ev, ech, epol, cyc, f, p, ch, d;
        logic [3:0] rdy;
        do_reset;
        for (int i = 0; i < 60; i++) begin
            if (i % 6 == 0) set_cfg(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
            ch = int'($urandom_range(0, 3));
            d = int'($urandom_range(0, 15));
            model_step(ch, d, f, p);
            run_sample(ch, d, ev, ech, epol, cyc, rdy);
            checks++; if (rdy !== 4'(1 << ch)) $display("FAIL rand%0d_ready got %b exp %b", i, rdy, 4'(1 << ch)); else passes++;
            checks++; if (ev != f || cyc != 2 || (f == 1 && (ech != ch || epol != p))) $display("FAIL rand%0d got ev=%0d ch=%0d pol=%0d cyc=%0d exp ev=%0d ch=%0d pol=%0d", i, ev, ech, epol, cyc, f, ch, p); else passes++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (int'(dut.prev[i]) != prev_m[i]) $display("FAIL rand_prev%0d got %0d exp %0d", i, dut.prev[i], prev_m[i]); else passes++;
        end
        checks++; if (int'(evt_count) != cnt_m) $display("FAIL rand_count got %0d exp %0d", evt_count, cnt_m); else passes++;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        test_reset;
        test_first_event;
        test_no_spike;
        test_suppressed_off;
        test_round_robin;
        test_stall;
        test_reset_mid;
        test_boundary;
        test_random;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/delta_scheduler.md
# delta_scheduler

Time-multiplexes a single delta comparator across NCH sample channels, turning raw 4-bit samples into on/off spike events. It sits between the per-channel sample sources and the spike output path. It owns the per-channel reference ("prev") registers, the shared threshold/off-spike configuration and round-robin channel arbitration, and it delivers events through a valid/ready handshake so a slow consumer stalls the scan.

## Interface
- NCH, 4: number of sample channels; power of two, 2..8.
- DW, 4: sample and threshold width in bits.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- cfg_we  in  1  write strobe for the configuration registers.
- cfg_threshold  in  DW  threshold value, captured when cfg_we=1.
- cfg_off_spike  in  1  off-spike enable, captured when cfg_we=1.
- sample_valid  in  NCH  per-channel sample available.
- sample_data  in  NCH*DW  packed samples; channel i occupies bits [i*DW +: DW].
- sample_ready  out  NCH  one-hot, one-cycle pulse that accepts the selected channel's sample.
- evt_valid  out  1  spike event pending.
- evt_ready  in  1  consumer accepts the event.
- evt_chan  out  log2(NCH)  channel that produced the event.
- evt_pol  out  1  1 = on spike (rising), 0 = off spike (falling).
- busy  out  1  FSM is not in SCAN.
- evt_count  out  8  saturating count of accepted events.

## Operation
- The FSM has three states: SCAN, CMP, EMIT. Reset state is SCAN.
- SCAN: search sample_valid round-robin, starting at rr_ptr and wrapping modulo NCH.
  - If a channel is valid, select it, pulse its sample_ready bit, latch data and channel, and go to CMP.
  - If no channel is valid, stay in SCAN and keep sample_ready at 0.
- CMP: the shared comparator evaluates the latched sample against prev[ch].
  - diff = |data - prev[ch]|, computed as an unsigned DW-bit magnitude with no wrap. The subtraction is done in DW+1 bits, or as max-min.
  - A spike occurs only when diff > threshold (strict).
  - If data > prev and a spike occurs: on event, pol=1.
  - If data < prev, a spike occurs and off_spike=1: off event, pol=0.
  - If data < prev, a spike occurs and off_spike=0: no event.
  - In every case where diff > threshold, prev[ch] <= data, including a suppressed off spike.
  - rr_ptr <= ch+1 mod NCH.
  - Go to EMIT if an event was produced, otherwise go to SCAN.
- EMIT: hold evt_valid=1. evt_chan and evt_pol stay stable until evt_ready=1.
  - On the handshake, increment evt_count (saturate at 255) and go to SCAN.
- Configuration:
  - cfg_we updates threshold and off_spike in any state.
  - The comparator uses the register values present in the CMP cycle.
  - A write in the same cycle as CMP is not seen by that compare.
- Reset values: prev[*]=0, threshold=0, off_spike=0, rr_ptr=0, evt_valid=0, evt_chan=0, evt_pol=0, sample_ready=0, busy=0, evt_count=0.

## Timing
- Sample accepted in cycle t (sample_ready pulse). Compare in cycle t+1. evt_valid rises at t+2.
- Minimum 3 cycles per event with evt_ready tied high. No-spike samples take 2 cycles each.
- sample_ready is combinational from the state, rr_ptr and sample_valid, and is asserted only in SCAN.
- Sources must hold sample_valid and sample_data until they see their ready bit.
- evt_valid must not drop without a handshake. The scan is stalled for the whole EMIT state.
- Equal samples (diff=0) never spike, even with threshold=0.
- Maximum swing (0 to 15, or 15 to 0) gives diff=15. It spikes for any threshold below 15 and never for threshold=15.
- Asserting rst_n low mid-operation clears evt_valid and sample_ready immediately (asynchronously). The pending event is lost. Restart is in SCAN with rr_ptr=0.

## Structure
- Shared package holds:
  - the state enum (SCAN, CMP, EMIT);
  - the event polarity constants POL_ON=1 and POL_OFF=0;
  - the evt_count saturation limit.
- One sub-module, delta_cmp: purely combinational. Inputs are data, prev, threshold and off_spike. Outputs are fire, pol and update_prev. It is instantiated once and shared by all channels.
- prev storage is an NCH x DW register array inside delta_scheduler.

## Test plan
- Reset, then threshold=2, off_spike=1, ch0 data 5: sample_ready=0001 at t, evt_valid at t+2 with chan=0, pol=1, prev[0]=5.
- ch0 data 5 then 6, threshold=2: no event, busy returns low after 2 cycles, prev[0] stays 5.
- off_spike=0, prev[1]=9, ch1 data 2, threshold=3: no event, but prev[1] becomes 2. Then off_spike=1, ch1 data 15 gives an on event with pol=1.
- All four channels valid continuously, each rising past threshold: events appear in order ch0, ch1, ch2, ch3, ch0, with rr_ptr wrapping at 3.
- evt_ready held low for 10 cycles in EMIT: evt_valid, chan and pol stay stable, sample_ready stays 0000, evt_count is unchanged until the handshake.
- rst_n pulsed low during EMIT: evt_valid drops immediately, prev[*]=0 and evt_count=0 afterwards, and the next sample on ch2 with data 15, threshold=14 produces an on event.
